// File: rtl/memory_p4.sv
// ----------------------------------------------------------------------------
// memory_p4 -- memory-access stage of the simple pipeline.
//
// Registers the execute-stage result into an EX/MEM register and performs at
// most one data-memory access per instruction over a req/ack handshake. While
// an access is waiting for its ack, upstream stages are frozen via `stall`.
// An access that sees no ack for TIMEOUT wait cycles is aborted: it completes
// with read data 0x0000 and raises the sticky `mem_fault`.
//
// Ports
//   clock, reset        clock (rising edge) / asynchronous active-low reset
//   ex_valid            EX holds a real instruction (0 = bubble)
//   op_mem_read/_write  load / store (mutually exclusive)
//   op_reg_write        instruction writes a register
//   op_cond_update      instruction updates the flags
//   rd_ex               destination register number
//   data_register_wire  ALU result (address for loads/stores)
//   ar_ex_forward       store data
//   cond                S,Z,C,V from the ALU
//   dmem_*              data-memory request/ack interface
//   stall               freeze PC, IF/ID and ID/EX this cycle
//   data_register_mem   EX/MEM ALU result (forwarding source)
//   rd_mem/reg_write_mem EX/MEM destination and valid-qualified write enable
//   data_for_res_wb     MEM/WB result (load data or ALU result)
//   rd_wb/reg_write_wb  MEM/WB destination and write enable
//   szcv                architectural flag register
//   mem_fault           sticky access-timeout indicator
// ----------------------------------------------------------------------------
module memory_p4 #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        op_mem_read,
    input  logic        op_mem_write,
    input  logic        op_reg_write,
    input  logic        op_cond_update,
    input  logic [2:0]  rd_ex,
    input  logic [15:0] data_register_wire,
    input  logic [15:0] ar_ex_forward,
    input  logic [3:0]  cond,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        stall,
    output logic [15:0] data_register_mem,
    output logic [2:0]  rd_mem,
    output logic        reg_write_mem,
    output logic [15:0] data_for_res_wb,
    output logic [2:0]  rd_wb,
    output logic        reg_write_wb,
    output logic [3:0]  szcv,
    output logic        mem_fault
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_e;

    // EX/MEM register
    logic        exm_valid_q, exm_read_q, exm_write_q, exm_regw_q;
    logic [2:0]  exm_rd_q;
    logic [15:0] exm_alu_q, exm_sdata_q;

    // access FSM and wait counter
    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    // MEM/WB register
    logic [15:0] wb_data_q, wb_data_d;
    logic [2:0]  wb_rd_q, wb_rd_d;
    logic        wb_regw_q, wb_regw_d;

    logic [3:0]  szcv_q;
    logic        fault_q;

    logic        in_access, timeout_hit, access_done, stall_w, ex_mem_op;

    // ------------------------------------------------------------------
    // Access status. An abort completes the access exactly like an ack,
    // so stall drops in the same cycle either way.
    // ------------------------------------------------------------------
    assign in_access   = (state_q == S_ACCESS);
    assign timeout_hit = in_access & ~dmem_ack & (cnt_q == TO_LIMIT);
    assign access_done = in_access & (dmem_ack | timeout_hit);
    assign stall_w     = in_access & ~access_done;
    assign ex_mem_op   = ex_valid & (op_mem_read | op_mem_write);

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                // stall is always 0 in IDLE, so EX/MEM loads this edge
                if (ex_mem_op) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                end
            end
            S_ACCESS: begin
                if (access_done) begin
                    state_d = ex_mem_op ? S_ACCESS : S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // MEM/WB next value: bubble unless the EX/MEM instruction retires now
    // ------------------------------------------------------------------
    always_comb begin
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        wb_regw_d = 1'b0;
        if (exm_valid_q && (!(exm_read_q || exm_write_q) || access_done)) begin
            if (exm_read_q) begin
                wb_data_d = timeout_hit ? 16'h0000 : dmem_rdata;
            end else begin
                wb_data_d = exm_alu_q;
            end
            wb_rd_d   = exm_rd_q;
            wb_regw_d = exm_regw_q & ~exm_write_q;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exm_valid_q <= 1'b0;
            exm_read_q  <= 1'b0;
            exm_write_q <= 1'b0;
            exm_regw_q  <= 1'b0;
            exm_rd_q    <= '0;
            exm_alu_q   <= '0;
            exm_sdata_q <= '0;
        end else if (!stall_w) begin
            exm_valid_q <= ex_valid;
            exm_read_q  <= op_mem_read;
            exm_write_q <= op_mem_write;
            exm_regw_q  <= op_reg_write;
            exm_rd_q    <= rd_ex;
            exm_alu_q   <= data_register_wire;
            exm_sdata_q <= ar_ex_forward;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_data_q <= '0;
            wb_rd_q   <= '0;
            wb_regw_q <= 1'b0;
        end else begin
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
            wb_regw_q <= wb_regw_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            szcv_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            if (ex_valid && op_cond_update && !stall_w) begin
                szcv_q <= cond;
            end
            if (timeout_hit) begin
                fault_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dmem_req          = in_access;
    assign dmem_we           = in_access & exm_write_q;
    assign dmem_addr         = exm_alu_q;
    assign dmem_wdata        = exm_sdata_q;
    assign stall             = stall_w;
    assign data_register_mem = exm_alu_q;
    assign rd_mem            = exm_rd_q;
    assign reg_write_mem     = exm_valid_q & exm_regw_q;
    assign data_for_res_wb   = wb_data_q;
    assign rd_wb             = wb_rd_q;
    assign reg_write_wb      = wb_regw_q;
    assign szcv              = szcv_q;
    assign mem_fault         = fault_q;

endmodule

// File: doc/memory_p4.md
# memory_p4

Fourth stage of the simple pipeline: memory access. It sits directly downstream of the execute stage. It registers the EX result, store data, destination and flags into an EX/MEM register, then performs one data-memory access through a req/ack handshake. While an access waits, it stalls the upstream stages. It publishes the EX/MEM value (`data_register_mem`) and the MEM/WB value (`data_for_res_wb`), which the execute stage uses as forwarding sources and write-back uses as the register result.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum wait cycles for `dmem_ack` before the access is aborted (1..255).

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  EX holds a real instruction (0 = bubble).
- `op_mem_read`, `op_mem_write`  in  1 each  load / store; never both high.
- `op_reg_write`  in  1  instruction writes a register.
- `op_cond_update`  in  1  instruction updates the flags.
- `rd_ex`  in  3  destination register number.
- `data_register_wire`  in  16  ALU result (load/store address or result).
- `ar_ex_forward`  in  16  store data, already forwarded.
- `cond`  in  4  S,Z,C,V from the ALU.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  16  access address.
- `dmem_wdata`  out  16  write data.
- `dmem_ack`  in  1  access complete this cycle.
- `dmem_rdata`  in  16  read data, valid while `dmem_ack`=1.
- `stall`  out  1  freeze PC, IF/ID and ID/EX this cycle.
- `data_register_mem`  out  16  EX/MEM ALU result.
- `rd_mem`, `reg_write_mem`  out  3, 1  EX/MEM destination and write enable (valid-qualified).
- `data_for_res_wb`  out  16  MEM/WB result (load data or ALU result).
- `rd_wb`, `reg_write_wb`  out  3, 1  MEM/WB destination and write enable.
- `szcv`  out  4  architectural flag register.
- `mem_fault`  out  1  sticky: a timeout has occurred.

## Operation
EX/MEM register:
- Loads on every edge with `stall`=0.
- Captures: valid, read, write, reg_write, rd, ALU result, store data.
- `reg_write_mem` = valid & reg_write.

Flags:
- `szcv` <= `cond` on an edge with `ex_valid` & `op_cond_update` & ~`stall`.
- Otherwise it holds.

Access FSM, two states:
- IDLE to ACCESS on the edge that loads a valid read or write into EX/MEM. The wait counter clears.
- In ACCESS:
  - `dmem_req`=1; `dmem_we` = write; `dmem_addr` = `data_register_mem`; `dmem_wdata` = stored data.
  - `dmem_ack`=1 ends the access. If the next EX instruction is a memory op, the FSM goes to ACCESS again with the counter cleared; otherwise it goes to IDLE.
  - `dmem_ack`=0 increments the counter.
  - When the counter reaches `TIMEOUT` and ack is still 0: abort, set `mem_fault`, treat the access as complete with read data 0x0000.
- The abort-completion cycle behaves exactly like an ack cycle.
- Outside ACCESS: `dmem_req`=0, `dmem_we`=0; address and write data are don't-care.

Stall:
- `stall` = ACCESS & ~`dmem_ack` & ~(timeout reached).
- It is combinational, the same cycle as ack.

MEM/WB register, loaded every edge:
- If EX/MEM is valid and (not a memory op, or the access completes this cycle):
  - `data_for_res_wb` = `dmem_rdata` for a load (0 on abort), else the ALU result.
  - `rd_wb` = rd; `reg_write_wb` = reg_write.
- Otherwise it loads a bubble: `reg_write_wb`=0, data and rd hold.
- A store never writes a register.

Load-use hazards are not detected here. `data_register_mem` is the address for loads; the hazard unit must not forward it as load data.

## Timing
- Reset values: all registers 0, FSM IDLE, `mem_fault`=0.
  - Hence `dmem_req`=0, `stall`=0, `szcv`=0000, all data outputs 0x0000.
- Reset is asynchronous. Asserting it mid-access drops `dmem_req` and `stall` immediately and discards the access.
- Zero-wait memory (ack in the first ACCESS cycle):
  - No stall.
  - A load result appears on `data_for_res_wb` one edge after the EX/MEM load.
  - Back-to-back memory ops run one per cycle.
- N wait cycles: `stall` is high for exactly N cycles. MEM/WB receives N bubbles, then the result.
- Timeout: `stall` is high for `TIMEOUT` cycles (counter 0..TIMEOUT-1). The completion edge follows. `mem_fault` is high from that edge until reset.
- ALU-only instructions pass EX to MEM to WB in 2 edges with no interaction with memory.

## Test plan
- Reset mid-access: assert `reset` while in ACCESS with ack=0 -> `dmem_req`, `stall`, `reg_write_wb` drop to 0 without a clock edge; after release, IDLE.
- ALU op with rd=3, result 0x1234, op_cond_update, cond=1001 -> `data_register_mem`=0x1234 and `szcv`=1001 after edge 1; `data_for_res_wb`=0x1234, `rd_wb`=3, `reg_write_wb`=1 after edge 2; `dmem_req` never 1.
- Load at addr 0x0040, ack after 2 wait cycles with rdata 0xBEEF -> `stall` high 2 cycles, `dmem_addr`=0x0040, `dmem_we`=0; `data_for_res_wb`=0xBEEF with `reg_write_wb`=1 after the ack edge; 2 prior bubbles.
- Store 0x5A5A to 0x0010, ack the same cycle, followed immediately by a load -> no stall; `dmem_we`=1 then 0 on consecutive cycles; store gives `reg_write_wb`=0.
- `TIMEOUT`=4, load with ack never given -> `stall` high exactly 4 cycles, then `mem_fault`=1 and `data_for_res_wb`=0x0000; `mem_fault` stays 1 through later good accesses.
